// File: rtl/mips_pkg.sv
// ============================================================================
//  Module   : mips_pkg
//  Brief    : Shared MIPS constants: instruction field positions/widths, the
//             NOP word, default PC width and IF/ID occupancy encodings.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mips_pkg;

    localparam int          c_PC_W      = 32;
    localparam logic [31:0] c_NOP_INSTR = 32'h0000_0000;

    localparam int c_OP_LSB    = 26;
    localparam int c_OP_W      = 6;
    localparam int c_RS_LSB    = 21;
    localparam int c_RT_LSB    = 16;
    localparam int c_RD_LSB    = 11;
    localparam int c_SHAMT_LSB = 6;
    localparam int c_REG_W     = 5;
    localparam int c_FUNCT_LSB = 0;
    localparam int c_FUNCT_W   = 6;
    localparam int c_IMM_LSB   = 0;
    localparam int c_IMM_W     = 16;
    localparam int c_ADDR_LSB  = 0;
    localparam int c_ADDR_W    = 26;

    // Occupancy encoded as {skid_valid, main_valid}; 2'b10 cannot occur.
    localparam logic [1:0] c_ST_EMPTY = 2'b00;
    localparam logic [1:0] c_ST_ONE   = 2'b01;
    localparam logic [1:0] c_ST_TWO   = 2'b11;

endpackage

`default_nettype wire

// File: rtl/mips_instr_fields.sv
// ============================================================================
//  Module   : mips_instr_fields
//  Brief    : Combinational slicer from a MIPS instruction word to its fields.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mips_instr_fields
    import mips_pkg::*;
(
    input  logic [31:0] i_instr,
    output logic [5:0]  o_op,
    output logic [4:0]  o_rs,
    output logic [4:0]  o_rt,
    output logic [4:0]  o_rd,
    output logic [4:0]  o_shamt,
    output logic [5:0]  o_funct,
    output logic [15:0] o_imm16,
    output logic [25:0] o_addr26
);

    assign o_op     = i_instr[c_OP_LSB    +: c_OP_W];
    assign o_rs     = i_instr[c_RS_LSB    +: c_REG_W];
    assign o_rt     = i_instr[c_RT_LSB    +: c_REG_W];
    assign o_rd     = i_instr[c_RD_LSB    +: c_REG_W];
    assign o_shamt  = i_instr[c_SHAMT_LSB +: c_REG_W];
    assign o_funct  = i_instr[c_FUNCT_LSB +: c_FUNCT_W];
    assign o_imm16  = i_instr[c_IMM_LSB   +: c_IMM_W];
    assign o_addr26 = i_instr[c_ADDR_LSB  +: c_ADDR_W];

endmodule

`default_nettype wire

// File: rtl/if_id_stage.sv
// ============================================================================
//  Module   : if_id_stage
//  Brief    : IF/ID pipeline register with a 2-entry skid buffer and
//             valid/ready handshakes. Optional stall counter enabled by
//             defining IF_ID_STALL_CNT_EN.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module if_id_stage
    import mips_pkg::*;
#(
    parameter int          PC_W        = c_PC_W,
    parameter logic [31:0] RESET_INSTR = c_NOP_INSTR,
    parameter int          STALL_CNT_W = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            if_valid,
    output logic            if_ready,
    input  logic [PC_W-1:0] if_pc4,
    input  logic [31:0]     if_instr,
    input  logic            flush,
    output logic            id_valid,
    input  logic            id_ready,
    output logic [PC_W-1:0] id_pc4,
    output logic [31:0]     id_instr,
    output logic [5:0]      id_op,
    output logic [4:0]      id_rs,
    output logic [4:0]      id_rt,
    output logic [4:0]      id_rd,
    output logic [4:0]      id_shamt,
    output logic [5:0]      id_funct,
    output logic [15:0]     id_imm16,
    output logic [25:0]     id_addr26
`ifdef IF_ID_STALL_CNT_EN
   ,output logic [STALL_CNT_W-1:0] stall_cnt
`endif
);

    logic            r_main_valid, r_skid_valid;
    logic [PC_W-1:0] r_main_pc4,   r_skid_pc4;
    logic [31:0]     r_main_instr, r_skid_instr;

    logic            w_nxt_main_valid, w_nxt_skid_valid;
    logic [PC_W-1:0] w_nxt_main_pc4,   w_nxt_skid_pc4;
    logic [31:0]     w_nxt_main_instr, w_nxt_skid_instr;

    logic [1:0] w_state;
    logic       w_accept, w_drain;

    assign w_state  = {r_skid_valid, r_main_valid};
    assign w_accept = if_valid & ~r_skid_valid;
    assign w_drain  = r_main_valid & id_ready;

    always_comb begin
        w_nxt_main_valid = r_main_valid;
        w_nxt_main_pc4   = r_main_pc4;
        w_nxt_main_instr = r_main_instr;
        w_nxt_skid_valid = r_skid_valid;
        w_nxt_skid_pc4   = r_skid_pc4;
        w_nxt_skid_instr = r_skid_instr;

        if (flush) begin
            w_nxt_main_valid = 1'b0;
            w_nxt_skid_valid = 1'b0;
            w_nxt_main_instr = RESET_INSTR;
        end else begin
            case (w_state)
                c_ST_EMPTY: begin
                    if (w_accept) begin
                        w_nxt_main_valid = 1'b1;
                        w_nxt_main_pc4   = if_pc4;
                        w_nxt_main_instr = if_instr;
                    end
                end
                c_ST_ONE: begin
                    if (w_accept && w_drain) begin
                        w_nxt_main_pc4   = if_pc4;
                        w_nxt_main_instr = if_instr;
                    end else if (w_accept) begin
                        w_nxt_skid_valid = 1'b1;
                        w_nxt_skid_pc4   = if_pc4;
                        w_nxt_skid_instr = if_instr;
                    end else if (w_drain) begin
                        w_nxt_main_valid = 1'b0;
                        w_nxt_main_instr = RESET_INSTR;
                    end
                end
                c_ST_TWO: begin
                    // Skid always promotes into main so ordering stays FIFO.
                    if (w_drain) begin
                        w_nxt_main_pc4   = r_skid_pc4;
                        w_nxt_main_instr = r_skid_instr;
                        w_nxt_skid_valid = 1'b0;
                    end
                end
                default: begin
                    w_nxt_main_valid = 1'b0;
                    w_nxt_skid_valid = 1'b0;
                    w_nxt_main_instr = RESET_INSTR;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
            r_main_pc4   <= '0;
            r_main_instr <= RESET_INSTR;
            r_skid_pc4   <= '0;
            r_skid_instr <= RESET_INSTR;
        end else begin
            r_main_valid <= w_nxt_main_valid;
            r_skid_valid <= w_nxt_skid_valid;
            r_main_pc4   <= w_nxt_main_pc4;
            r_main_instr <= w_nxt_main_instr;
            r_skid_pc4   <= w_nxt_skid_pc4;
            r_skid_instr <= w_nxt_skid_instr;
        end
    end

    // Registered-only ready: no combinational path from id_ready.
    assign if_ready = ~r_skid_valid;
    assign id_valid = r_main_valid;
    assign id_pc4   = r_main_pc4;
    assign id_instr = r_main_instr;

    mips_instr_fields u_fields (
        .i_instr  (id_instr),
        .o_op     (id_op),
        .o_rs     (id_rs),
        .o_rt     (id_rt),
        .o_rd     (id_rd),
        .o_shamt  (id_shamt),
        .o_funct  (id_funct),
        .o_imm16  (id_imm16),
        .o_addr26 (id_addr26)
    );

`ifdef IF_ID_STALL_CNT_EN
    logic [STALL_CNT_W-1:0] r_stall_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (r_main_valid && !id_ready && !flush) begin
            r_stall_cnt <= r_stall_cnt + STALL_CNT_W'(1);
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_if_id_stage.sv
// ============================================================================
//  Module   : tb_if_id_stage
//  Brief    : Directed self-checking bench for if_id_stage.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_if_id_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_pc4;
    logic [31:0] if_instr;
    logic        flush;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_pc4;
    logic [31:0] id_instr;
    logic [5:0]  id_op;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic [4:0]  id_rd;
    logic [4:0]  id_shamt;
    logic [5:0]  id_funct;
    logic [15:0] id_imm16;
    logic [25:0] id_addr26;
`ifdef IF_ID_STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    if_id_stage #(
        .PC_W        (32),
        .RESET_INSTR (32'h0000_0000),
        .STALL_CNT_W (32)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .if_valid  (if_valid),
        .if_ready  (if_ready),
        .if_pc4    (if_pc4),
        .if_instr  (if_instr),
        .flush     (flush),
        .id_valid  (id_valid),
        .id_ready  (id_ready),
        .id_pc4    (id_pc4),
        .id_instr  (id_instr),
        .id_op     (id_op),
        .id_rs     (id_rs),
        .id_rt     (id_rt),
        .id_rd     (id_rd),
        .id_shamt  (id_shamt),
        .id_funct  (id_funct),
        .id_imm16  (id_imm16),
        .id_addr26 (id_addr26)
`ifdef IF_ID_STALL_CNT_EN
       ,.stall_cnt (stall_cnt)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1ns after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic v, input logic [31:0] pc4, input logic [31:0] instr);
        if_valid = v;
        if_pc4   = pc4;
        if_instr = instr;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; id_ready = 1'b0;
        offer(1'b0, 32'h0, 32'h0);
        tick(); tick();
        rst = 1'b0;
        check("rst_id_valid", {31'b0, id_valid}, 32'd0);
        check("rst_if_ready", {31'b0, if_ready}, 32'd1);
        check("rst_id_instr", id_instr, 32'h0);
        check("rst_id_pc4",   id_pc4,   32'h0);

        // Single beat: addi $t0,$0,-1
        id_ready = 1'b1;
        offer(1'b1, 32'h0000_3004, 32'h2008_FFFF);
        tick();
        offer(1'b0, 32'h0, 32'h0);
        check("single_valid", {31'b0, id_valid}, 32'd1);
        check("single_pc4",   id_pc4, 32'h0000_3004);
        check("single_op",    {26'b0, id_op}, 32'h08);
        check("single_rs",    {27'b0, id_rs}, 32'd0);
        check("single_rt",    {27'b0, id_rt}, 32'd8);
        check("single_imm16", {16'b0, id_imm16}, 32'h0000_FFFF);
        check("single_addr26", {6'b0, id_addr26}, 32'h0008_FFFF);
        tick();
        check("drain_valid", {31'b0, id_valid}, 32'd0);
        check("drain_instr", id_instr, 32'h0);

        // Backpressure fill: A then B, C held off
        id_ready = 1'b0;
        offer(1'b1, 32'h0000_3004, 32'h0123_4567);
        tick();
        check("bp_a_ready", {31'b0, if_ready}, 32'd1);
        offer(1'b1, 32'h0000_3008, 32'h89AB_CDEF);
        tick();
        check("bp_b_ready", {31'b0, if_ready}, 32'd0);
        check("bp_b_pc4",   id_pc4, 32'h0000_3004);
        offer(1'b1, 32'h0000_300C, 32'h0043_1020);
        tick();
        check("bp_two_hold", {31'b0, if_ready}, 32'd0);
        check("bp_out_a",    id_instr, 32'h0123_4567);
        id_ready = 1'b1;
        tick();
        check("bp_out_b_pc4", id_pc4, 32'h0000_3008);
        check("bp_out_b_ins", id_instr, 32'h89AB_CDEF);
        check("bp_ready_back", {31'b0, if_ready}, 32'd1);
        tick();
        offer(1'b0, 32'h0, 32'h0);
        check("bp_out_c_pc4", id_pc4, 32'h0000_300C);
        check("bp_c_rs",    {27'b0, id_rs},    32'd2);
        check("bp_c_rt",    {27'b0, id_rt},    32'd3);
        check("bp_c_rd",    {27'b0, id_rd},    32'd2);
        check("bp_c_funct", {26'b0, id_funct}, 32'h20);
        tick();
        check("bp_empty", {31'b0, id_valid}, 32'd0);

        // Continuous streaming
        id_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            offer(1'b1, 32'h0000_3004 + 32'(4 * i), 32'hA000_0000 + 32'(i));
            tick();
            check("stream_pc4",   id_pc4, 32'h0000_3004 + 32'(4 * i));
            check("stream_valid", {31'b0, id_valid}, 32'd1);
            check("stream_ready", {31'b0, if_ready}, 32'd1);
        end
        offer(1'b0, 32'h0, 32'h0);
        tick();
        check("stream_end", {31'b0, id_valid}, 32'd0);

        // Flush in TWO state with C offered
        id_ready = 1'b0;
        offer(1'b1, 32'h0000_3004, 32'h1111_1111);
        tick();
        offer(1'b1, 32'h0000_3008, 32'h2222_2222);
        tick();
        check("fl_two", {31'b0, if_ready}, 32'd0);
        flush = 1'b1;
        offer(1'b1, 32'h0000_300C, 32'h3333_3333);
        tick();
        flush = 1'b0;
        offer(1'b0, 32'h0, 32'h0);
        check("fl_valid", {31'b0, id_valid}, 32'd0);
        check("fl_ready", {31'b0, if_ready}, 32'd1);
        check("fl_instr", id_instr, 32'h0);
        id_ready = 1'b1;
        tick();
        check("fl_no_c", {31'b0, id_valid}, 32'd0);

        // Flush with main only, offered entry in ONE state dropped
        id_ready = 1'b0;
        offer(1'b1, 32'h0000_3010, 32'h4444_4444);
        tick();
        flush = 1'b1;
        offer(1'b1, 32'h0000_3014, 32'h5555_5555);
        tick();
        flush = 1'b0;
        offer(1'b0, 32'h0, 32'h0);
        check("fl1_valid", {31'b0, id_valid}, 32'd0);

        // Reset mid-stall in TWO state
        offer(1'b1, 32'h0000_3004, 32'h6666_6666);
        tick();
        offer(1'b1, 32'h0000_3008, 32'h7777_7777);
        tick();
        offer(1'b0, 32'h0, 32'h0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rs_valid", {31'b0, id_valid}, 32'd0);
        check("rs_ready", {31'b0, if_ready}, 32'd1);
        check("rs_instr", id_instr, 32'h0);
        check("rs_pc4",   id_pc4,   32'h0);
`ifdef IF_ID_STALL_CNT_EN
        check("rs_stall_cnt", stall_cnt, 32'd0);

        // Five stalled cycles, then a flush that must not count or clear
        offer(1'b1, 32'h0000_3004, 32'h8888_8888);
        tick();
        offer(1'b0, 32'h0, 32'h0);
        check("sc_start", stall_cnt, 32'd0);
        repeat (5) tick();
        check("sc_five", stall_cnt, 32'd5);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("sc_flush", stall_cnt, 32'd5);
        tick();
        check("sc_hold", stall_cnt, 32'd5);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/if_id_stage.md
Name: if_id_stage

Overview:
- IF/ID pipeline register for the 5-stage MIPS datapath. Sits between instruction fetch and decode.
- Holds each fetched {PC+4, instruction} pair in a 2-entry skid buffer, with a valid/ready handshake on both sides.
- Presents decoded instruction fields to ID. The imm16 field feeds the sign-extension unit directly.

Parameters:
PC_W, 32, width of PC+4 value
RESET_INSTR, 32'h0000_0000, instruction word presented when no entry is held (sll $0,$0,0 = NOP)
STALL_CNT_W, 32, width of optional stall counter

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-high reset
if_valid  in  1  IF offers an instruction this cycle
if_ready  out  1  stage can accept; registered, = ~skid_valid
if_pc4  in  PC_W  PC+4 of offered instruction
if_instr  in  32  offered instruction word
flush  in  1  taken branch/jump: discard all held and incoming entries
id_valid  out  1  id_* outputs hold a live instruction
id_ready  in  1  ID consumes the entry this cycle
id_pc4  out  PC_W  PC+4 of held instruction
id_instr  out  32  held instruction word
id_op  out  6  id_instr[31:26]
id_rs  out  5  id_instr[25:21]
id_rt  out  5  id_instr[20:16]
id_rd  out  5  id_instr[15:11]
id_shamt  out  5  id_instr[10:6]
id_funct  out  6  id_instr[5:0]
id_imm16  out  16  id_instr[15:0], to sign extender
id_addr26  out  26  id_instr[25:0], jump target

Behaviour:
- Storage: main entry (main_valid, main_pc4, main_instr) and skid entry (skid_valid, skid_pc4, skid_instr).
- id_valid = main_valid. id_pc4/id_instr come from the main entry. All field outputs are pure slices of id_instr.
- Reset (rst=1 at a clk edge): main_valid = skid_valid = 0, id_pc4 = 0, id_instr = RESET_INSTR, if_ready = 1 on the next cycle. Reset mid-transfer drops both entries; no partial state survives.
- Definitions: accept = if_valid & if_ready; drain = main_valid & id_ready.
- States, encoded by {skid_valid, main_valid}:
  - EMPTY (00): accept → ONE, incoming written to main.
  - ONE (01):
    - accept & drain → ONE, main overwritten.
    - accept & ~drain → TWO, incoming written to skid.
    - ~accept & drain → EMPTY.
    - otherwise hold.
  - TWO (11): if_ready = 0, so no accept.
    - drain → ONE, skid moved to main, skid cleared.
    - ~drain → hold.
- State 10 is unreachable. On a drain with no new data, main_instr returns to RESET_INSTR and main_pc4 holds its value (don't-care).
- Latency: an instruction accepted at edge N appears on id_* after edge N (1 cycle) when the stage was EMPTY, or when it was ONE and drained in the same cycle.
- Ordering: strictly FIFO; the skid entry never overtakes main.
- flush has priority over accept, drain and rst-free updates:
  - Next state is EMPTY and main_instr = RESET_INSTR.
  - The entry offered in the flush cycle is dropped, even if if_ready = 1.
- Simultaneous flush and rst: reset wins. The result is the same state either way.
- if_ready depends only on registered state, so there is no combinational path from id_ready to if_ready.
- No arithmetic is performed. Fields are fixed MIPS slices and never reordered.

Optional Feature:
- Macro: IF_ID_STALL_CNT_EN.
- Defined:
  - Adds output stall_cnt [STALL_CNT_W-1:0].
  - Increments by 1 on every cycle where main_valid & ~id_ready & ~flush.
  - Wraps modulo 2^STALL_CNT_W.
  - Cleared by rst only; flush does not clear it.
- Undefined: the port and the counter are absent. All other behaviour is identical.

Decomposition:
- Shared package mips_pkg holds:
  - OP/FUNCT field bit positions and widths.
  - NOP_INSTR = 32'h0000_0000.
  - The PC_W default.
- One natural sub-module: mips_instr_fields, a combinational slicer from the instruction word to op/rs/rt/rd/shamt/funct/imm16/addr26. It is reusable by later stages (ID/EX debug taps).
- Storage and FSM stay in if_id_stage.

Test Plan:
- Reset, then single beat:
  - Stimulus: if_valid=1, if_pc4=32'h0000_3004, if_instr=32'h2008_FFFF (addi $t0,$0,-1), id_ready=1.
  - Response: next cycle id_valid=1, id_op=6'h08, id_rt=5'd8, id_imm16=16'hFFFF. After the drain, id_valid=0 and id_instr=0.
- Backpressure fill:
  - Stimulus: id_ready=0; offer A (pc4 3004), then B (pc4 3008).
  - Response: if_ready drops to 0 after B is accepted. C (pc4 300C) is held off by IF.
  - Then id_ready=1: outputs A, then B, then C in consecutive cycles.
- Continuous streaming: if_valid=1 and id_ready=1 for 8 cycles with pc4 3004..3020. Required: id_pc4 follows 1 cycle behind, no bubbles, if_ready stays 1.
- Flush in TWO state: with A in main and B in skid, assert flush with if_valid=1 offering C. Required: next cycle id_valid=0, if_ready=1, C is never seen at ID.
- Reset mid-stall: in TWO state, assert rst for 1 cycle. Required: id_valid=0, if_ready=1, id_instr=0. With IF_ID_STALL_CNT_EN defined, stall_cnt=0.
- IF_ID_STALL_CNT_EN: hold main valid with id_ready=0 for 5 cycles, then 1 flush cycle. Required: stall_cnt=5 and stays 5 after the flush.
